// File: rtl/spike_rate_monitor.sv
// Spike rate / inter-spike interval monitor for the LIF neuron output.
// Ports: clk, rst (sync, active-high), en (counter advance), spike_in (level),
//   rate_ready (consumer ack), rate_out/rate_valid (window count, valid/ready),
//   isi_out/isi_valid (interval, one-cycle pulse), overrun (sticky drop flag).
module spike_rate_monitor #(
   parameter int WINDOW_LEN = 256,
   parameter int CNT_W      = 8,
   parameter int ISI_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   input  logic             rate_ready,
   output logic [CNT_W-1:0] rate_out,
   output logic             rate_valid,
   output logic [ISI_W-1:0] isi_out,
   output logic             isi_valid,
   output logic             overrun
);

   localparam int WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

   logic             r_spike_prev;
   logic             r_have_spike;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_spk_cnt;
   logic [ISI_W-1:0] r_isi_cnt;
   logic [CNT_W-1:0] r_rate_out;
   logic             r_rate_valid;
   logic [ISI_W-1:0] r_isi_out;
   logic             r_isi_valid;
   logic             r_overrun;

   logic             w_event;
   logic             w_term;
   logic             w_xfer;
   logic [CNT_W-1:0] w_result;
   logic [ISI_W-1:0] w_isi_meas;

   assign w_event = spike_in & ~r_spike_prev & en;
   assign w_term  = en & (r_win_cnt == WIN_LAST);
   assign w_xfer  = r_rate_valid & rate_ready;

   // Closing count includes an event landing on the terminal cycle.
   assign w_result = (w_event && !(&r_spk_cnt)) ?
                     r_spk_cnt + CNT_W'(1) : r_spk_cnt;

   // isi_cnt holds (elapsed - 1) when the next event arrives.
   assign w_isi_meas = (&r_isi_cnt) ? r_isi_cnt : r_isi_cnt + ISI_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_spike_prev <= 1'b0;
         r_have_spike <= 1'b0;
         r_win_cnt    <= '0;
         r_spk_cnt    <= '0;
         r_isi_cnt    <= '0;
         r_rate_out   <= '0;
         r_rate_valid <= 1'b0;
         r_isi_out    <= '0;
         r_isi_valid  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_spike_prev <= spike_in;
         r_isi_valid  <= 1'b0;

         if (en) begin
            r_win_cnt <= w_term ? '0 : r_win_cnt + WIN_W'(1);
         end

         if (w_term) begin
            r_spk_cnt <= '0;
         end else if (w_event && !(&r_spk_cnt)) begin
            r_spk_cnt <= r_spk_cnt + CNT_W'(1);
         end

         // Rate handshake: a pending, unaccepted result blocks new data.
         if (w_term) begin
            if (!r_rate_valid || w_xfer) begin
               r_rate_out   <= w_result;
               r_rate_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (w_xfer) begin
            r_rate_valid <= 1'b0;
         end

         if (w_event) begin
            r_isi_cnt    <= '0;
            r_have_spike <= 1'b1;
            if (r_have_spike) begin
               r_isi_out   <= w_isi_meas;
               r_isi_valid <= 1'b1;
            end
         end else if (en && !(&r_isi_cnt)) begin
            r_isi_cnt <= r_isi_cnt + ISI_W'(1);
         end
      end
   end

   assign rate_out   = r_rate_out;
   assign rate_valid = r_rate_valid;
   assign isi_out    = r_isi_out;
   assign isi_valid  = r_isi_valid;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor (WINDOW_LEN=16, CNT_W=4, ISI_W=4).
// Directed scenarios followed by random stimulus against a behavioural model.
module tb_spike_rate_monitor;

   localparam int WL   = 16;
   localparam int CMAX = 15;
   localparam int IMAX = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       spike_in = 1'b0;
   logic       rate_ready = 1'b0;
   logic [3:0] rate_out;
   logic       rate_valid;
   logic [3:0] isi_out;
   logic       isi_valid;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   // Behavioural model: absolute enabled-cycle indices since reset.
   bit m_prev;
   int m_ecount;
   int m_win;
   int m_last;
   int m_rate_out;
   bit m_rate_valid;
   bit m_overrun;
   int m_isi_out;
   bit m_isi_valid;

   spike_rate_monitor #(
      .WINDOW_LEN(16),
      .CNT_W     (4),
      .ISI_W     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .spike_in  (spike_in),
      .rate_ready(rate_ready),
      .rate_out  (rate_out),
      .rate_valid(rate_valid),
      .isi_out   (isi_out),
      .isi_valid (isi_valid),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit e, input bit s, input bit rd);
      bit ev;
      bit xfer;
      int res;
      if (r) begin
         m_prev = 0; m_ecount = 0; m_win = 0; m_last = -1;
         m_rate_out = 0; m_rate_valid = 0; m_overrun = 0;
         m_isi_out = 0; m_isi_valid = 0;
         return;
      end
      ev   = e && s && !m_prev;
      xfer = m_rate_valid && rd;
      m_isi_valid = 0;
      if (ev) begin
         if (m_last >= 0) begin
            m_isi_out   = (m_ecount - m_last > IMAX) ? IMAX : m_ecount - m_last;
            m_isi_valid = 1;
         end
         m_last = m_ecount;
         m_win++;
      end
      if (e && (m_ecount % WL == WL - 1)) begin
         res = (m_win > CMAX) ? CMAX : m_win;
         if (!m_rate_valid || xfer) begin
            m_rate_out   = res;
            m_rate_valid = 1;
         end else begin
            m_overrun = 1;
         end
         m_win = 0;
      end else if (xfer) begin
         m_rate_valid = 0;
      end
      if (e) m_ecount++;
      m_prev = s;
   endtask

   task automatic step(input bit r, input bit e, input bit s, input bit rd);
      rst = r; en = e; spike_in = s; rate_ready = rd;
      @(posedge clk);
      model(r, e, s, rd);
      #1;
      chk("rate_out", rate_out, m_rate_out);
      chk("rate_valid", rate_valid, m_rate_valid);
      chk("isi_out", isi_out, m_isi_out);
      chk("isi_valid", isi_valid, m_isi_valid);
      chk("overrun", overrun, m_overrun);
   endtask

   task automatic idle(input int n, input bit rd);
      for (int i = 0; i < n; i++) step(0, 1, 0, rd);
   endtask

   initial begin
      int k;
      // Reset
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_rate_out", rate_out, 0);
      chk("rst_rate_valid", rate_valid, 0);
      chk("rst_overrun", overrun, 0);

      // 1) Three spikes in window 0, ready high
      for (int i = 0; i < 16; i++)
         step(0, 1, (i == 1 || i == 4 || i == 8), 1);
      chk("s1_rate_out", rate_out, 3);
      chk("s1_rate_valid", rate_valid, 1);
      step(0, 1, 0, 1);
      chk("s1_valid_drop", rate_valid, 0);

      // 2) Spikes at enabled cycles 2, 7, 9
      step(1, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         step(0, 1, (i == 2 || i == 7 || i == 9), 1);
         if (i == 2) chk("s2_first_noisi", isi_valid, 0);
         if (i == 7) begin
            chk("s2_isi5", isi_out, 5);
            chk("s2_isi5_v", isi_valid, 1);
         end
         if (i == 9) chk("s2_isi2", isi_out, 2);
      end

      // 3) Spikes 20 apart saturate; level-high spike is one event
      step(0, 1, 1, 1);
      idle(19, 1);
      step(0, 1, 1, 1);
      chk("s3_isi_sat", isi_out, 15);
      idle(3, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 1);
      idle(4, 1);

      // 4) Ready low over two windows: 1 spike then 4 spikes
      step(1, 0, 0, 0);
      for (int i = 0; i < 32; i++)
         step(0, 1, (i == 3 || i == 17 || i == 20 || i == 23 || i == 26), 0);
      chk("s4_rate_hold", rate_out, 1);
      chk("s4_overrun", overrun, 1);
      step(0, 1, 0, 1);
      chk("s4_xfer", rate_valid, 0);

      // 5) Spike on terminal cycle, another early in the new window;
      //    ready and terminal coincide with data pending
      k = 0;
      while (m_ecount % WL != WL - 2 && k < 64) begin
         step(0, 1, 0, 0);
         k++;
      end
      step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      idle(13, 0);
      step(0, 1, 0, 1);
      chk("s5_valid_stays", rate_valid, 1);
      step(0, 1, 0, 1);

      // 6) en low for 10 cycles with an edge, then reset mid-window
      step(1, 0, 0, 0);
      idle(5, 1);
      for (int i = 0; i < 10; i++) step(0, 0, (i >= 3 && i < 6), 1);
      idle(10, 1);
      chk("s6_not_yet", rate_valid, 0);
      idle(1, 1);
      chk("s6_delayed_end", rate_valid, 1);
      chk("s6_edge_lost", rate_out, 0);
      idle(6, 0);
      step(1, 1, 1, 0);
      chk("s6_rst_valid", rate_valid, 0);
      idle(20, 1);

      // Random stimulus
      for (int i = 0; i < 600; i++)
         step(($urandom_range(99) == 0), ($urandom_range(9) < 8),
              ($urandom_range(3) == 0), $urandom_range(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
